// File: rtl/cheri_tsmap_arbiter.sv
// Arbitrates the single-port tsmap SRAM between never-stalling revocation lookups and bus RMW traffic.
// Lookups own the port whenever requested; a deferred RMW write is forwarded to lookups until it lands.
module cheri_tsmap_arbiter #(
  parameter int TSMapSize = 1024,
  parameter int AddrW     = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             trvk_cs_i,
  input  logic [AddrW-1:0] trvk_addr_i,
  output logic [31:0]      trvk_rdata_o,
  input  logic             bus_req_i,
  output logic             bus_gnt_o,
  input  logic [1:0]       bus_op_i,
  input  logic [AddrW-1:0] bus_addr_i,
  input  logic [31:0]      bus_wdata_i,
  output logic             bus_rvalid_o,
  output logic [31:0]      bus_rdata_o,
  output logic             bus_err_o,
  output logic             mem_cs_o,
  output logic             mem_we_o,
  output logic [AddrW-1:0] mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  input  logic [31:0]      mem_rdata_i
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RDW  = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_SET = 2'b10;

  localparam logic [AddrW:0] LP_SIZE = (AddrW+1)'(TSMapSize);

  logic [1:0]       r_state;
  logic [1:0]       r_op;
  logic [AddrW-1:0] r_addr;
  logic [31:0]      r_wdata;
  logic             r_err;
  logic [31:0]      r_rdata;
  logic [31:0]      r_wbuf;
  logic             r_trvk_pend;
  logic             r_fwd_hit;

  logic [1:0]       w_state_d;
  logic             w_oob;
  logic             w_gnt;
  logic             w_capture;
  logic             w_rmw_load;
  logic             w_cs;
  logic             w_we;
  logic [AddrW-1:0] w_addr;
  logic [31:0]      w_wdata;
  logic             w_rvalid;
  logic [31:0]      w_rdata;
  logic             w_err;
  logic [31:0]      w_mod;

  assign w_oob = ({1'b0, bus_addr_i} >= LP_SIZE);
  assign w_mod = (r_op == OP_SET) ? (mem_rdata_i | r_wdata) : (mem_rdata_i & ~r_wdata);

  always_comb begin
    w_state_d  = r_state;
    w_gnt      = 1'b0;
    w_capture  = 1'b0;
    w_rmw_load = 1'b0;
    w_cs       = 1'b0;
    w_we       = 1'b0;
    w_addr     = '0;
    w_wdata    = '0;
    w_rvalid   = 1'b0;
    w_rdata    = '0;
    w_err      = 1'b0;
    // Lookups win the port outright; the bus paths below only run when they are idle.
    if (trvk_cs_i) begin
      w_cs   = 1'b1;
      w_addr = trvk_addr_i;
    end
    case (r_state)
      ST_IDLE: begin
        if (bus_req_i && !trvk_cs_i) begin
          w_gnt     = 1'b1;
          w_capture = 1'b1;
          if (w_oob) begin
            w_state_d = ST_RESP;
          end else if (bus_op_i == OP_WR) begin
            w_cs      = 1'b1;
            w_we      = 1'b1;
            w_addr    = bus_addr_i;
            w_wdata   = bus_wdata_i;
            w_state_d = ST_RESP;
          end else begin
            w_cs      = 1'b1;
            w_addr    = bus_addr_i;
            w_state_d = ST_RDW;
          end
        end
      end
      ST_RDW: begin
        if (r_op == OP_RD) begin
          w_rvalid  = 1'b1;
          w_rdata   = mem_rdata_i;
          w_state_d = ST_IDLE;
        end else begin
          w_rmw_load = 1'b1;
          w_state_d  = ST_WR;
        end
      end
      ST_WR: begin
        if (!trvk_cs_i) begin
          w_cs      = 1'b1;
          w_we      = 1'b1;
          w_addr    = r_addr;
          w_wdata   = r_wbuf;
          w_state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        w_rvalid  = 1'b1;
        w_err     = r_err;
        w_rdata   = (r_err || (r_op == OP_WR)) ? 32'd0 : r_rdata;
        w_state_d = ST_IDLE;
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_RD;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_wbuf      <= '0;
      r_trvk_pend <= 1'b0;
      r_fwd_hit   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_trvk_pend <= trvk_cs_i;
      r_fwd_hit   <= trvk_cs_i && (r_state == ST_WR) && (trvk_addr_i == r_addr);
      if (w_capture) begin
        r_op    <= bus_op_i;
        r_addr  <= bus_addr_i;
        r_wdata <= bus_wdata_i;
        r_err   <= w_oob;
      end
      if (w_rmw_load) begin
        r_rdata <= mem_rdata_i;
        r_wbuf  <= w_mod;
      end
    end
  end

  // Combinational port drive is held quiet while reset is asserted.
  assign bus_gnt_o    = rst_ni & w_gnt;
  assign mem_cs_o     = rst_ni & w_cs;
  assign mem_we_o     = rst_ni & w_we;
  assign mem_addr_o   = rst_ni ? w_addr : '0;
  assign mem_wdata_o  = rst_ni ? w_wdata : '0;
  assign bus_rvalid_o = w_rvalid;
  assign bus_rdata_o  = w_rdata;
  assign bus_err_o    = w_err;
  assign trvk_rdata_o = !r_trvk_pend ? 32'd0 : (r_fwd_hit ? r_wbuf : mem_rdata_i);

endmodule

// File: tb/tb_cheri_tsmap_arbiter.sv
// Directed bench for cheri_tsmap_arbiter with an SRAM model and response scoreboards.
module tb_cheri_tsmap_arbiter;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        trvk_cs_i;
  logic [15:0] trvk_addr_i;
  logic [31:0] trvk_rdata_o;
  logic        bus_req_i;
  logic        bus_gnt_o;
  logic [1:0]  bus_op_i;
  logic [15:0] bus_addr_i;
  logic [31:0] bus_wdata_i;
  logic        bus_rvalid_o;
  logic [31:0] bus_rdata_o;
  logic        bus_err_o;
  logic        mem_cs_o;
  logic        mem_we_o;
  logic [15:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  int n_err = 0;
  int n_chk = 0;

  logic [32:0] bus_q[$];
  logic [31:0] trvk_q[$];
  logic        we_forbid = 1'b0;
  logic        mon_pend = 1'b0;

  logic [31:0] mem [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_addr = '0;
  logic [31:0] pl_dat = '0;

  cheri_tsmap_arbiter #(.TSMapSize(1024), .AddrW(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .trvk_cs_i(trvk_cs_i), .trvk_addr_i(trvk_addr_i), .trvk_rdata_o(trvk_rdata_o),
    .bus_req_i(bus_req_i), .bus_gnt_o(bus_gnt_o), .bus_op_i(bus_op_i),
    .bus_addr_i(bus_addr_i), .bus_wdata_i(bus_wdata_i),
    .bus_rvalid_o(bus_rvalid_o), .bus_rdata_o(bus_rdata_o), .bus_err_o(bus_err_o),
    .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  // Single-port SRAM, 1-cycle read latency, with a bench-side preload port.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_dat;
    else if (mem_cs_o) begin
      if (mem_we_o) mem[mem_addr_o[9:0]] <= mem_wdata_o;
      else mem_rdata_i <= mem[mem_addr_o[9:0]];
    end
  end

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_dat = d;
    nxt();
    pl_en = 1'b0;
  endtask

  // Scoreboard side: lookup data one cycle after each request, bus responses on rvalid.
  always @(negedge clk) begin
    if (mon_pend) begin
      if (trvk_q.size() == 0) begin
        n_chk++; n_err++;
        $error("FAIL trvk_unexpected observed=%h expected=none", trvk_rdata_o);
      end else chk("trvk_rdata", {1'b0, trvk_rdata_o}, {1'b0, trvk_q.pop_front()});
    end else begin
      chk("trvk_idle_zero", {1'b0, trvk_rdata_o}, 33'd0);
    end
    mon_pend = trvk_cs_i & rst_ni;
    if (bus_rvalid_o) begin
      if (bus_q.size() == 0) begin
        n_chk++; n_err++;
        $error("FAIL bus_unexpected observed=%h expected=none", {bus_err_o, bus_rdata_o});
      end else chk("bus_resp", {bus_err_o, bus_rdata_o}, bus_q.pop_front());
    end
    if (we_forbid) chk("no_sram_write", {32'd0, mem_we_o}, 33'd0);
  end

  initial begin
    rst_ni = 1'b0; trvk_cs_i = 1'b0; trvk_addr_i = '0;
    bus_req_i = 1'b0; bus_op_i = '0; bus_addr_i = '0; bus_wdata_i = '0;
    preload(10'd5, 32'hA5A5_0000);
    preload(10'd3, 32'h0000_00F0);
    preload(10'd1, 32'h1111_1111);
    preload(10'd2, 32'h2222_2222);
    preload(10'd7, 32'hFFFF_FFFF);
    preload(10'd9, 32'h0000_0010);
    preload(10'd0, 32'h5555_5555);
    @(negedge clk);
    chk("rst_gnt",    {32'd0, bus_gnt_o},    33'd0);
    chk("rst_cs",     {32'd0, mem_cs_o},     33'd0);
    chk("rst_we",     {32'd0, mem_we_o},     33'd0);
    chk("rst_rvalid", {32'd0, bus_rvalid_o}, 33'd0);
    chk("rst_err",    {32'd0, bus_err_o},    33'd0);
    nxt(); rst_ni = 1'b1; we_forbid = 1'b1;

    // Plain lookup
    nxt(); trvk_cs_i = 1'b1; trvk_addr_i = 16'd5; trvk_q.push_back(32'hA5A5_0000);
    @(negedge clk);
    chk("t1_cs",   {32'd0, mem_cs_o}, 33'd1);
    chk("t1_we",   {32'd0, mem_we_o}, 33'd0);
    chk("t1_addr", {17'd0, mem_addr_o}, 33'd5);
    nxt(); trvk_cs_i = 1'b0;
    @(negedge clk); we_forbid = 1'b0;

    // Set-bits RMW with no lookup traffic
    nxt(); bus_req_i = 1'b1; bus_op_i = 2'b10; bus_addr_i = 16'd3; bus_wdata_i = 32'h0000_000F;
    bus_q.push_back({1'b0, 32'h0000_00F0});
    @(negedge clk);
    chk("t2_gnt",  {32'd0, bus_gnt_o}, 33'd1);
    chk("t2_rd",   {31'd0, mem_cs_o, mem_we_o}, 33'd2);
    chk("t2_addr", {17'd0, mem_addr_o}, 33'd3);
    nxt(); bus_req_i = 1'b0;
    @(negedge clk); chk("t2_rdw_idle", {32'd0, mem_cs_o}, 33'd0);
    nxt(); @(negedge clk);
    chk("t2_wr",    {31'd0, mem_cs_o, mem_we_o}, 33'd3);
    chk("t2_waddr", {17'd0, mem_addr_o}, 33'd3);
    chk("t2_wdata", {1'b0, mem_wdata_o}, {1'b0, 32'h0000_00FF});
    nxt(); @(negedge clk); chk("t2_rvalid", {32'd0, bus_rvalid_o}, 33'd1);
    nxt(); @(negedge clk); chk("t2_pulse", {32'd0, bus_rvalid_o}, 33'd0);

    // Bus read held off by three back-to-back lookups
    for (int i = 0; i < 3; i++) begin
      nxt(); bus_req_i = 1'b1; bus_op_i = 2'b00; bus_addr_i = 16'd3;
      trvk_cs_i = 1'b1; trvk_addr_i = 16'(i + 1);
      trvk_q.push_back(i == 0 ? 32'h1111_1111 : (i == 1 ? 32'h2222_2222 : 32'h0000_00FF));
      @(negedge clk);
      chk("t3_no_gnt", {32'd0, bus_gnt_o}, 33'd0);
      chk("t3_taddr",  {17'd0, mem_addr_o}, 33'(i + 1));
    end
    nxt(); trvk_cs_i = 1'b0; bus_q.push_back({1'b0, 32'h0000_00FF});
    @(negedge clk); chk("t3_gnt", {32'd0, bus_gnt_o}, 33'd1);
    nxt(); bus_req_i = 1'b0;
    @(negedge clk); chk("t3_rvalid", {32'd0, bus_rvalid_o}, 33'd1);

    // Word write, then lookup sees it
    nxt(); bus_req_i = 1'b1; bus_op_i = 2'b01; bus_addr_i = 16'd12; bus_wdata_i = 32'hDEAD_BEEF;
    bus_q.push_back(33'd0);
    @(negedge clk);
    chk("tw_we",    {31'd0, mem_cs_o, mem_we_o}, 33'd3);
    chk("tw_wdata", {1'b0, mem_wdata_o}, {1'b0, 32'hDEAD_BEEF});
    nxt(); bus_req_i = 1'b0; trvk_cs_i = 1'b1; trvk_addr_i = 16'd12; trvk_q.push_back(32'hDEAD_BEEF);
    @(negedge clk); chk("tw_rvalid", {32'd0, bus_rvalid_o}, 33'd1);
    nxt(); trvk_cs_i = 1'b0;

    // Clear-bits RMW with lookups colliding on the same word
    nxt(); bus_req_i = 1'b1; bus_op_i = 2'b11; bus_addr_i = 16'd7; bus_wdata_i = 32'h0000_0001;
    bus_q.push_back({1'b0, 32'hFFFF_FFFF});
    @(negedge clk); chk("t4_gnt", {32'd0, bus_gnt_o}, 33'd1);
    nxt(); bus_req_i = 1'b0; trvk_cs_i = 1'b1; trvk_addr_i = 16'd7; trvk_q.push_back(32'hFFFF_FFFF);
    nxt(); trvk_q.push_back(32'hFFFF_FFFE);
    @(negedge clk); chk("t4_defer1", {32'd0, mem_we_o}, 33'd0);
    nxt(); trvk_q.push_back(32'hFFFF_FFFE);
    @(negedge clk); chk("t4_defer2", {32'd0, mem_we_o}, 33'd0);
    nxt(); trvk_cs_i = 1'b0;
    @(negedge clk);
    chk("t4_wr",    {31'd0, mem_cs_o, mem_we_o}, 33'd3);
    chk("t4_waddr", {17'd0, mem_addr_o}, 33'd7);
    chk("t4_wdata", {1'b0, mem_wdata_o}, {1'b0, 32'hFFFF_FFFE});
    nxt(); trvk_cs_i = 1'b1; trvk_addr_i = 16'd7; trvk_q.push_back(32'hFFFF_FFFE);
    @(negedge clk); chk("t4_rvalid", {32'd0, bus_rvalid_o}, 33'd1);
    nxt(); trvk_cs_i = 1'b0;

    // Out-of-range read
    nxt(); bus_req_i = 1'b1; bus_op_i = 2'b00; bus_addr_i = 16'd1024;
    bus_q.push_back({1'b1, 32'd0});
    @(negedge clk);
    chk("t5_gnt", {32'd0, bus_gnt_o}, 33'd1);
    chk("t5_cs",  {32'd0, mem_cs_o},  33'd0);
    nxt(); bus_req_i = 1'b0;
    @(negedge clk);
    chk("t5_rvalid", {32'd0, bus_rvalid_o}, 33'd1);
    chk("t5_cs2",    {32'd0, mem_cs_o},     33'd0);

    // Reset while the RMW write is deferred
    we_forbid = 1'b1;
    nxt(); bus_req_i = 1'b1; bus_op_i = 2'b10; bus_addr_i = 16'd9; bus_wdata_i = 32'h0000_0001;
    @(negedge clk); chk("t6_gnt", {32'd0, bus_gnt_o}, 33'd1);
    nxt(); bus_req_i = 1'b0;
    nxt(); trvk_cs_i = 1'b1; trvk_addr_i = 16'd0; trvk_q.push_back(32'd0);
    nxt(); rst_ni = 1'b0; trvk_cs_i = 1'b0;
    #1;
    chk("t6_cs",     {32'd0, mem_cs_o},     33'd0);
    chk("t6_we",     {32'd0, mem_we_o},     33'd0);
    chk("t6_gnt0",   {32'd0, bus_gnt_o},    33'd0);
    chk("t6_rvalid", {32'd0, bus_rvalid_o}, 33'd0);
    chk("t6_trvk",   {1'b0, trvk_rdata_o},  33'd0);
    nxt(); nxt(); rst_ni = 1'b1;
    nxt(); bus_req_i = 1'b1; bus_op_i = 2'b00; bus_addr_i = 16'd9;
    bus_q.push_back({1'b0, 32'h0000_0010});
    @(negedge clk); chk("t6_post_gnt", {32'd0, bus_gnt_o}, 33'd1);
    nxt(); bus_req_i = 1'b0;
    @(negedge clk); chk("t6_post_rvalid", {32'd0, bus_rvalid_o}, 33'd1);
    nxt(); we_forbid = 1'b0;

    chk("sram7", {1'b0, mem[7]}, {1'b0, 32'hFFFF_FFFE});
    chk("sram9", {1'b0, mem[9]}, {1'b0, 32'h0000_0010});
    for (int k = 0; k < 20; k++) begin
      if (bus_q.size() == 0 && trvk_q.size() == 0) break;
      nxt();
    end
    chk("bus_q_drained",  33'(bus_q.size()),  33'd0);
    chk("trvk_q_drained", 33'(trvk_q.size()), 33'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cheri_tsmap_arbiter.md
Name: cheri_tsmap_arbiter

Overview:
Shares the single-port revocation shadow-map (tsmap) SRAM between two requesters. The load-revocation stage performs fixed-latency bit lookups that can never stall. A bus-side requester (allocator/revoker software via MMIO) performs word reads, word writes and atomic bit-set/bit-clear read-modify-writes. The block sits between both requesters and the tsmap SRAM and forwards pending RMW data so lookups always see coherent map state.

Parameters:
TSMapSize, 1024, number of 32-bit tsmap words; valid word addresses are 0..TSMapSize-1.
AddrW, 16, tsmap word-address width.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
trvk_cs_i  in  1  revocation-stage lookup request
trvk_addr_i  in  AddrW  lookup word address
trvk_rdata_o  out  32  lookup data, valid the cycle after trvk_cs_i
bus_req_i  in  1  bus request
bus_gnt_o  out  1  request accepted this cycle
bus_op_i  in  2  00 read, 01 write, 10 set bits (OR), 11 clear bits (AND-NOT)
bus_addr_i  in  AddrW  word address
bus_wdata_i  in  32  write data / bit mask
bus_rvalid_o  out  1  response valid (1-cycle pulse)
bus_rdata_o  out  32  read data; for set/clear, the pre-modify word
bus_err_o  out  1  qualifies bus_rvalid_o: address out of range
mem_cs_o  out  1  SRAM select
mem_we_o  out  1  SRAM write enable
mem_addr_o  out  AddrW  SRAM address
mem_wdata_o  out  32  SRAM write data
mem_rdata_i  in  32  SRAM read data, 1-cycle latency

Behaviour:
- Reset: FSM=IDLE; all outputs 0; write buffer, captured request and trvk pending flag cleared. Reset mid-RMW drops the pending write. SRAM is not touched.
- Priority: trvk_cs_i always owns the port that cycle (mem_cs_o=1, mem_we_o=0, mem_addr_o=trvk_addr_i). Bus traffic waits; there is no bus starvation bound.
- trvk_pend_q <= trvk_cs_i. trvk_rdata_o = fwd_hit_q ? wbuf_q : mem_rdata_i, else 0 when trvk_pend_q=0.
- FSM IDLE: bus_gnt_o = bus_req_i & ~trvk_cs_i (combinational). On grant, capture op/addr/wdata.
  - If addr >= TSMapSize: go to RESP with err=1, rdata=0, no SRAM access.
  - If op is write: issue SRAM write of bus_wdata_i this cycle, go to RESP.
  - Otherwise: issue SRAM read this cycle, go to RDW.
- FSM RDW: mem_rdata_i is the bus word. The SRAM port is free for trvk this cycle.
  - For read: bus_rvalid_o=1, bus_rdata_o=mem_rdata_i, go to IDLE.
  - For set/clear: rdata_q <= mem_rdata_i; wbuf_q <= mem_rdata_i | wdata (set) or mem_rdata_i & ~wdata (clear); go to WR.
- FSM WR: if trvk_cs_i, stay in WR (write deferred). Otherwise issue SRAM write of wbuf_q at the captured address and go to RESP.
- FSM RESP: bus_rvalid_o=1 for exactly one cycle. For write, rdata=0. For set/clear, rdata=rdata_q (old word). bus_err_o per capture. Go to IDLE. No new grant in RESP.
- Forwarding: fwd_hit_q <= trvk_cs_i & (state==WR) & (trvk_addr_i==captured addr).
  - A lookup in the RDW cycle returns the old word; the RMW is linearised at the end of RDW.
  - Lookups during WR return the new word.
  - A lookup after the write cycle reads the updated SRAM.
- At most one bus transaction is outstanding. bus_req_i must be held until bus_gnt_o.
- Address compare uses the full AddrW width; no wrap-around.

Test Plan:
- Reset then trvk_cs_i at addr 5 with SRAM[5]=0xA5A5_0000 -> trvk_rdata_o=0xA5A5_0000 next cycle; mem_we_o never 1.
- Bus set op, addr 3, SRAM[3]=0x0000_00F0, mask 0x0000_000F, no trvk traffic -> grant in cycle 0; read in cycle 0; write 0x0000_00FF in cycle 2; bus_rvalid_o in cycle 3 with rdata=0x0000_00F0, err=0.
- Bus req and trvk_cs_i asserted together for 3 cycles -> bus_gnt_o=0 for those cycles; grant in the first cycle trvk_cs_i=0; lookups unaffected.
- Clear op on addr 7 (old 0xFFFF_FFFF, mask 0x1) with trvk_cs_i to addr 7 held during WR for 2 cycles -> write deferred 2 cycles; both lookups return 0xFFFF_FFFE via forwarding; final SRAM[7]=0xFFFF_FFFE.
- Bus read at addr TSMapSize (1024) -> no mem_cs_o; bus_rvalid_o=1 with bus_err_o=1, rdata=0, 1 cycle after grant.
- Assert rst_ni=0 while in WR -> outputs 0 immediately; no SRAM write ever issued; first post-reset bus request is granted from IDLE.
